// File: rtl/issue_pkg.sv
// Shared widths and ALU/branch opcode encodings for the integer issue/execute unit.
// The branch opcodes only take effect when CDB_BRANCH_EN is defined.
package issue_pkg;

    localparam int DATA_W_DEFAULT = 32;
    localparam int TAG_W_DEFAULT  = 6;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SLL  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_SLT  = 4'd8;
    localparam logic [3:0] ALU_SLTU = 4'd9;
    localparam logic [3:0] BR_BEQ   = 4'd10;
    localparam logic [3:0] BR_BNE   = 4'd11;

endpackage

// File: rtl/mul_pipe.sv
// Fixed-latency unsigned multiplier: MUL_LATENCY-1 stages of {valid, tag, product}.
// The product is formed on entry; later stages only carry it toward the CDB.
module mul_pipe import issue_pkg::*; #(
    parameter int DATA_W      = DATA_W_DEFAULT,
    parameter int TAG_W       = TAG_W_DEFAULT,
    parameter int MUL_LATENCY = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [TAG_W-1:0]  in_tag,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    output logic              out_valid,
    output logic [TAG_W-1:0]  out_tag,
    output logic [DATA_W-1:0] out_data
);

    localparam int STAGES = MUL_LATENCY - 1;

    logic [STAGES-1:0] valid_q;
    logic [TAG_W-1:0]  tag_q  [STAGES];
    logic [DATA_W-1:0] prod_q [STAGES];

    always_ff @(posedge clk) begin
        if (!reset) begin
            valid_q <= '0;
        end else begin
            valid_q[0] <= in_valid;
            for (int i = 1; i < STAGES; i++) begin
                valid_q[i] <= valid_q[i-1];
            end
        end
    end

    // Payload needs no reset: it is only ever observed behind its valid bit.
    always_ff @(posedge clk) begin
        tag_q[0]  <= in_tag;
        prod_q[0] <= in_a * in_b;
        for (int i = 1; i < STAGES; i++) begin
            tag_q[i]  <= tag_q[i-1];
            prod_q[i] <= prod_q[i-1];
        end
    end

    assign out_valid = valid_q[STAGES-1];
    assign out_tag   = tag_q[STAGES-1];
    assign out_data  = prod_q[STAGES-1];

endmodule

// File: rtl/int_issue_exec_unit.sv
// Issue responder for the integer and multiplier RSs: single-cycle ALU, pipelined
// multiplier, one CDB result per cycle. Define CDB_BRANCH_EN for BEQ/BNE branch results.
module int_issue_exec_unit import issue_pkg::*; #(
    parameter int DATA_W       = DATA_W_DEFAULT,
    parameter int TAG_W        = TAG_W_DEFAULT,
    parameter int MUL_LATENCY  = 3,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              int_ready,
    input  logic [DATA_W-1:0] int_rs1_data,
    input  logic [DATA_W-1:0] int_rs2_data,
    input  logic [TAG_W-1:0]  int_rd_tag,
    input  logic [3:0]        int_opcode,
    output logic              int_issue_done,
    input  logic              mul_ready,
    input  logic [DATA_W-1:0] mul_rs1_data,
    input  logic [DATA_W-1:0] mul_rs2_data,
    input  logic [TAG_W-1:0]  mul_rd_tag,
    output logic              mul_issue_done,
`ifdef CDB_BRANCH_EN
    output logic              cdb_branch,
    output logic              cdb_branch_taken,
`endif
    output logic              cdb_valid,
    output logic [TAG_W-1:0]  cdb_tag,
    output logic [DATA_W-1:0] cdb_data
);

    localparam int                CNT_W   = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0]  LIMIT_C = CNT_W'(STARVE_LIMIT);

    logic              mul_hit;
    logic [TAG_W-1:0]  mul_tag;
    logic [DATA_W-1:0] mul_data;
    logic [CNT_W-1:0]  starve_cnt;
    logic              throttle;
    logic [DATA_W-1:0] alu_result;
    logic [4:0]        shamt;

    mul_pipe #(
        .DATA_W      (DATA_W),
        .TAG_W       (TAG_W),
        .MUL_LATENCY (MUL_LATENCY)
    ) u_mul_pipe (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (mul_issue_done),
        .in_tag    (mul_rd_tag),
        .in_a      (mul_rs1_data),
        .in_b      (mul_rs2_data),
        .out_valid (mul_hit),
        .out_tag   (mul_tag),
        .out_data  (mul_data)
    );

    // An int is only accepted when the CDB slot at the next edge is free of a mul result.
    assign throttle       = (starve_cnt == LIMIT_C);
    assign mul_issue_done = reset & mul_ready & ~throttle;
    assign int_issue_done = reset & int_ready & ~mul_hit;

    always_ff @(posedge clk) begin
        if (!reset) begin
            starve_cnt <= '0;
        end else if (int_ready && !int_issue_done) begin
            if (starve_cnt != LIMIT_C) begin
                starve_cnt <= starve_cnt + CNT_W'(1);
            end
        end else begin
            starve_cnt <= '0;
        end
    end

    assign shamt = int_rs2_data[4:0];

    always_comb begin
        alu_result = '0;
        case (int_opcode)
            ALU_ADD:  alu_result = int_rs1_data + int_rs2_data;
            ALU_SUB:  alu_result = int_rs1_data - int_rs2_data;
            ALU_AND:  alu_result = int_rs1_data & int_rs2_data;
            ALU_OR:   alu_result = int_rs1_data | int_rs2_data;
            ALU_XOR:  alu_result = int_rs1_data ^ int_rs2_data;
            ALU_SLL:  alu_result = int_rs1_data << shamt;
            ALU_SRL:  alu_result = int_rs1_data >> shamt;
            ALU_SRA:  alu_result = $unsigned($signed(int_rs1_data) >>> shamt);
            ALU_SLT:  alu_result = DATA_W'($signed(int_rs1_data) < $signed(int_rs2_data));
            ALU_SLTU: alu_result = DATA_W'(int_rs1_data < int_rs2_data);
            default:  alu_result = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cdb_valid <= 1'b0;
            cdb_tag   <= '0;
            cdb_data  <= '0;
        end else if (mul_hit) begin
            cdb_valid <= 1'b1;
            cdb_tag   <= mul_tag;
            cdb_data  <= mul_data;
        end else if (int_issue_done) begin
            cdb_valid <= 1'b1;
            cdb_tag   <= int_rd_tag;
            cdb_data  <= alu_result;
        end else begin
            cdb_valid <= 1'b0;
        end
    end

`ifdef CDB_BRANCH_EN
    logic alu_branch;
    logic alu_taken;

    always_comb begin
        alu_branch = 1'b0;
        alu_taken  = 1'b0;
        if (int_opcode == BR_BEQ) begin
            alu_branch = 1'b1;
            alu_taken  = (int_rs1_data == int_rs2_data);
        end else if (int_opcode == BR_BNE) begin
            alu_branch = 1'b1;
            alu_taken  = (int_rs1_data != int_rs2_data);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset || mul_hit || !int_issue_done) begin
            cdb_branch       <= 1'b0;
            cdb_branch_taken <= 1'b0;
        end else begin
            cdb_branch       <= alu_branch;
            cdb_branch_taken <= alu_taken;
        end
    end
`endif

endmodule

// File: tb/tb_int_issue_exec_unit.sv
// Self-checking bench for int_issue_exec_unit: directed scenarios plus a randomized run
// against a cycle-indexed reference schedule. Branch checks apply when CDB_BRANCH_EN is defined.
module tb_int_issue_exec_unit;

    localparam int L     = 3;
    localparam int LIMIT = 4;
    localparam int NR    = 3000;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        int_ready = 1'b0;
    logic [31:0] int_rs1_data = '0;
    logic [31:0] int_rs2_data = '0;
    logic [5:0]  int_rd_tag = '0;
    logic [3:0]  int_opcode = '0;
    logic        int_issue_done;
    logic        mul_ready = 1'b0;
    logic [31:0] mul_rs1_data = '0;
    logic [31:0] mul_rs2_data = '0;
    logic [5:0]  mul_rd_tag = '0;
    logic        mul_issue_done;
    logic        cdb_valid;
    logic [5:0]  cdb_tag;
    logic [31:0] cdb_data;
`ifdef CDB_BRANCH_EN
    logic        cdb_branch;
    logic        cdb_branch_taken;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    bit          ev_v [0:NR+L+4];
    logic [5:0]  ev_t [0:NR+L+4];
    logic [31:0] ev_d [0:NR+L+4];
    bit          macc [0:NR+L+4];

    always #5 clk = ~clk;

    int_issue_exec_unit dut (
        .clk            (clk),
        .reset          (reset),
        .int_ready      (int_ready),
        .int_rs1_data   (int_rs1_data),
        .int_rs2_data   (int_rs2_data),
        .int_rd_tag     (int_rd_tag),
        .int_opcode     (int_opcode),
        .int_issue_done (int_issue_done),
        .mul_ready      (mul_ready),
        .mul_rs1_data   (mul_rs1_data),
        .mul_rs2_data   (mul_rs2_data),
        .mul_rd_tag     (mul_rd_tag),
        .mul_issue_done (mul_issue_done),
`ifdef CDB_BRANCH_EN
        .cdb_branch       (cdb_branch),
        .cdb_branch_taken (cdb_branch_taken),
`endif
        .cdb_valid      (cdb_valid),
        .cdb_tag        (cdb_tag),
        .cdb_data       (cdb_data)
    );

    // Inputs change 1ns after the rising edge; outputs are sampled on the falling edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        int_ready = 1'b0;
        mul_ready = 1'b0;
        for (int i = 0; i < n; i++) next_cycle();
    endtask

    function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        int unsigned s;
        s = b % 32;
        case (op)
            4'd0: return a + b;
            4'd1: return a - b;
            4'd2: return a & b;
            4'd3: return a | b;
            4'd4: return a ^ b;
            4'd5: return a << s;
            4'd6: return a >> s;
            4'd7: return a[31] ? ((a >> s) | ~(32'hFFFF_FFFF >> s)) : (a >> s);
            4'd8: return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
            4'd9: return (a < b) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    task automatic test_reset();
        reset = 1'b0;
        int_ready = 1'b1;
        mul_ready = 1'b1;
        next_cycle();
        next_cycle();
        @(negedge clk);
        n_checks++; if (int_issue_done !== 1'b0) begin n_fail++; $display("FAIL reset_int_done: got %0b expected 0", int_issue_done); end
        n_checks++; if (mul_issue_done !== 1'b0) begin n_fail++; $display("FAIL reset_mul_done: got %0b expected 0", mul_issue_done); end
        n_checks++; if (cdb_valid !== 1'b0) begin n_fail++; $display("FAIL reset_cdb_valid: got %0b expected 0", cdb_valid); end
        n_checks++; if (cdb_tag !== 6'd0) begin n_fail++; $display("FAIL reset_cdb_tag: got %0h expected 0", cdb_tag); end
        n_checks++; if (cdb_data !== 32'd0) begin n_fail++; $display("FAIL reset_cdb_data: got %0h expected 0", cdb_data); end
        int_ready = 1'b0;
        mul_ready = 1'b0;
        next_cycle();
    endtask

    task automatic test_int_add();
        reset = 1'b1;
        int_ready = 1'b1; int_rs1_data = 32'd5; int_rs2_data = 32'd7; int_opcode = 4'd0; int_rd_tag = 6'd3;
        @(negedge clk);
        n_checks++; if (int_issue_done !== 1'b1) begin n_fail++; $display("FAIL add_issue_done: got %0b expected 1", int_issue_done); end
        next_cycle();
        int_ready = 1'b0;
        @(negedge clk);
        n_checks++; if (cdb_valid !== 1'b1 || cdb_tag !== 6'd3 || cdb_data !== 32'd12) begin
            n_fail++; $display("FAIL add_cdb: got v=%0b t=%0d d=%0d expected v=1 t=3 d=12", cdb_valid, cdb_tag, cdb_data);
        end
        next_cycle();
        @(negedge clk);
        n_checks++; if (cdb_valid !== 1'b0 || cdb_tag !== 6'd3 || cdb_data !== 32'd12) begin
            n_fail++; $display("FAIL add_cdb_hold: got v=%0b t=%0d d=%0d expected v=0 t=3 d=12", cdb_valid, cdb_tag, cdb_data);
        end
        idle(2);
    endtask

    task automatic test_mul();
        mul_ready = 1'b1; mul_rs1_data = 32'd6; mul_rs2_data = 32'd7; mul_rd_tag = 6'd9;
        @(negedge clk);
        n_checks++; if (mul_issue_done !== 1'b1) begin n_fail++; $display("FAIL mul_issue_done: got %0b expected 1", mul_issue_done); end
        for (int k = 1; k <= 4; k++) begin
            next_cycle();
            mul_ready = 1'b0;
            @(negedge clk);
            n_checks++; if (cdb_valid !== (k == L)) begin n_fail++; $display("FAIL mul_cdb_valid_c%0d: got %0b expected %0b", k, cdb_valid, (k == L)); end
            if (k == L) begin
                n_checks++; if (cdb_tag !== 6'd9 || cdb_data !== 32'd42) begin
                    n_fail++; $display("FAIL mul_cdb_result: got t=%0d d=%0d expected t=9 d=42", cdb_tag, cdb_data);
                end
            end
        end
        idle(2);
    endtask

    task automatic test_collision();
        mul_ready = 1'b1; mul_rs1_data = 32'd6; mul_rs2_data = 32'd7; mul_rd_tag = 6'd9;
        next_cycle();
        mul_ready = 1'b0;
        next_cycle();
        int_ready = 1'b1; int_rs1_data = 32'd1; int_rs2_data = 32'd2; int_opcode = 4'd0; int_rd_tag = 6'd4;
        @(negedge clk);
        n_checks++; if (int_issue_done !== 1'b0) begin n_fail++; $display("FAIL coll_int_blocked: got %0b expected 0", int_issue_done); end
        next_cycle();
        @(negedge clk);
        n_checks++; if (int_issue_done !== 1'b1) begin n_fail++; $display("FAIL coll_int_accept: got %0b expected 1", int_issue_done); end
        n_checks++; if (cdb_valid !== 1'b1 || cdb_tag !== 6'd9) begin n_fail++; $display("FAIL coll_cdb_mul: got v=%0b t=%0d expected v=1 t=9", cdb_valid, cdb_tag); end
        next_cycle();
        int_ready = 1'b0;
        @(negedge clk);
        n_checks++; if (cdb_valid !== 1'b1 || cdb_tag !== 6'd4 || cdb_data !== 32'd3) begin
            n_fail++; $display("FAIL coll_cdb_int: got v=%0b t=%0d d=%0d expected v=1 t=4 d=3", cdb_valid, cdb_tag, cdb_data);
        end
        idle(2);
    endtask

    task automatic test_starvation();
        bit exp_mul, exp_int;
        mul_ready = 1'b1; mul_rs1_data = 32'd2; mul_rs2_data = 32'd3; mul_rd_tag = 6'd20;
        for (int i = 0; i < 3; i++) next_cycle();
        int_ready = 1'b1; int_rs1_data = 32'd10; int_rs2_data = 32'd20; int_opcode = 4'd0; int_rd_tag = 6'd5;
        for (int c = 0; c <= 7; c++) begin
            if (c == 7) int_ready = 1'b0;
            exp_mul = !(c >= 4 && c <= 6);
            exp_int = (c == 6);
            @(negedge clk);
            n_checks++; if (mul_issue_done !== exp_mul) begin n_fail++; $display("FAIL starve_mul_c%0d: got %0b expected %0b", c, mul_issue_done, exp_mul); end
            if (c <= 6) begin
                n_checks++; if (int_issue_done !== exp_int) begin n_fail++; $display("FAIL starve_int_c%0d: got %0b expected %0b", c, int_issue_done, exp_int); end
            end
            if (c == 7) begin
                n_checks++; if (cdb_valid !== 1'b1 || cdb_tag !== 6'd5 || cdb_data !== 32'd30) begin
                    n_fail++; $display("FAIL starve_int_cdb: got v=%0b t=%0d d=%0d expected v=1 t=5 d=30", cdb_valid, cdb_tag, cdb_data);
                end
            end
            next_cycle();
        end
        idle(5);
    endtask

    task automatic test_arith();
        logic [3:0]  ops [6];
        logic [31:0] as  [6];
        logic [31:0] bs  [6];
        logic [31:0] exp [6];
        ops = '{4'd1, 4'd7, 4'd8, 4'd9, 4'd6, 4'd13};
        as  = '{32'd0, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 32'd99};
        bs  = '{32'd1, 32'd4, 32'd1, 32'd1, 32'd36, 32'd5};
        exp = '{32'hFFFF_FFFF, 32'hF800_0000, 32'd1, 32'd0, 32'h0800_0000, 32'd0};
        for (int i = 0; i < 6; i++) begin
            int_ready = 1'b1; int_opcode = ops[i]; int_rs1_data = as[i]; int_rs2_data = bs[i]; int_rd_tag = 6'(i + 40);
            next_cycle();
            int_ready = 1'b0;
            @(negedge clk);
            n_checks++; if (cdb_valid !== 1'b1 || cdb_tag !== 6'(i + 40) || cdb_data !== exp[i]) begin
                n_fail++; $display("FAIL arith_op%0d: got v=%0b t=%0d d=%0h expected v=1 t=%0d d=%0h", ops[i], cdb_valid, cdb_tag, cdb_data, i + 40, exp[i]);
            end
        end
        idle(2);
    endtask

    task automatic test_reset_midflight();
        mul_ready = 1'b1; mul_rs1_data = 32'd6; mul_rs2_data = 32'd7; mul_rd_tag = 6'd9;
        @(negedge clk);
        n_checks++; if (mul_issue_done !== 1'b1) begin n_fail++; $display("FAIL midrst_accept: got %0b expected 1", mul_issue_done); end
        next_cycle();
        reset = 1'b0; int_ready = 1'b1;
        @(negedge clk);
        n_checks++; if (mul_issue_done !== 1'b0 || int_issue_done !== 1'b0) begin
            n_fail++; $display("FAIL midrst_done_forced: got m=%0b i=%0b expected 0 0", mul_issue_done, int_issue_done);
        end
        next_cycle();
        reset = 1'b1; int_ready = 1'b0; mul_ready = 1'b0;
        @(negedge clk);
        n_checks++; if (cdb_tag !== 6'd0 || cdb_data !== 32'd0) begin n_fail++; $display("FAIL midrst_cdb_clear: got t=%0d d=%0h expected 0 0", cdb_tag, cdb_data); end
        for (int c = 2; c <= 5; c++) begin
            n_checks++; if (cdb_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_valid_c%0d: got %0b expected 0", c, cdb_valid); end
            next_cycle();
            @(negedge clk);
        end
`ifdef CDB_BRANCH_EN
        for (int i = 0; i < 3; i++) begin
            int_ready = 1'b1; int_rs1_data = 32'd3; int_rs2_data = 32'd3; int_rd_tag = 6'd7;
            int_opcode = (i == 0) ? 4'd10 : ((i == 1) ? 4'd11 : 4'd0);
            next_cycle();
            int_ready = 1'b0;
            @(negedge clk);
            n_checks++; if (cdb_valid !== 1'b1 || cdb_branch !== (i < 2) || cdb_branch_taken !== (i == 0) || cdb_data !== ((i == 2) ? 32'd6 : 32'd0)) begin
                n_fail++; $display("FAIL branch_%0d: got v=%0b br=%0b tk=%0b d=%0h", i, cdb_valid, cdb_branch, cdb_branch_taken, cdb_data);
            end
        end
`endif
        idle(2);
    endtask

    task automatic test_random();
        int          blocked;
        bit          ir, mr, hit, e_int, e_mul;
        int          mp;
        logic [5:0]  last_t;
        logic [31:0] last_d;
        blocked = 0;
        last_t = '0;
        last_d = '0;
        for (int i = 0; i <= NR + L + 4; i++) begin ev_v[i] = 1'b0; macc[i] = 1'b0; end
        reset = 1'b0; int_ready = 1'b0; mul_ready = 1'b0;
        next_cycle();
        reset = 1'b1;
        for (int n = 0; n < NR + L + 1; n++) begin
            mp = ((n / 150) % 2 == 1) ? 95 : 40;
            ir = (n < NR) && ($urandom_range(0, 99) < 60);
            mr = (n < NR) && ($urandom_range(0, 99) < mp);
            int_ready = ir; mul_ready = mr;
            int_opcode = 4'($urandom_range(0, 15));
            int_rs1_data = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
            int_rs2_data = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
            int_rd_tag = 6'($urandom);
            mul_rs1_data = $urandom; mul_rs2_data = $urandom; mul_rd_tag = 6'($urandom);
            hit = (n + 1 - L >= 0) ? macc[n + 1 - L] : 1'b0;
            e_int = ir && !hit;
            e_mul = mr && (blocked < LIMIT);
            @(negedge clk);
            n_checks++; if (int_issue_done !== e_int) begin n_fail++; $display("FAIL rnd_int_done_c%0d: got %0b expected %0b", n, int_issue_done, e_int); end
            n_checks++; if (mul_issue_done !== e_mul) begin n_fail++; $display("FAIL rnd_mul_done_c%0d: got %0b expected %0b", n, mul_issue_done, e_mul); end
            n_checks++; if (cdb_valid !== ev_v[n]) begin n_fail++; $display("FAIL rnd_cdb_valid_c%0d: got %0b expected %0b", n, cdb_valid, ev_v[n]); end
            if (ev_v[n]) begin
                last_t = ev_t[n];
                last_d = ev_d[n];
            end
            n_checks++; if (cdb_tag !== last_t || cdb_data !== last_d) begin
                n_fail++; $display("FAIL rnd_cdb_payload_c%0d: got t=%0d d=%0h expected t=%0d d=%0h", n, cdb_tag, cdb_data, last_t, last_d);
            end
            macc[n] = e_mul;
            if (e_mul) begin
                ev_v[n + L] = 1'b1; ev_t[n + L] = mul_rd_tag; ev_d[n + L] = mul_rs1_data * mul_rs2_data;
            end
            if (e_int) begin
                ev_v[n + 1] = 1'b1; ev_t[n + 1] = int_rd_tag; ev_d[n + 1] = ref_alu(int_opcode, int_rs1_data, int_rs2_data);
            end
            blocked = (ir && !e_int) ? blocked + 1 : 0;
            next_cycle();
        end
        idle(2);
    endtask

    initial begin
        test_reset();
        test_int_add();
        test_mul();
        test_collision();
        test_starvation();
        test_arith();
        test_reset_midflight();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/int_issue_exec_unit.md
Name: int_issue_exec_unit

Overview:
Responder end of the reservation-station issue handshake. It accepts ready instructions from the integer and multiplier reservation stations and pulses each station's issue-done. It executes integer ops in 1 cycle and multiplies in a fixed-latency pipeline. It publishes one result per cycle on the CDB (tag/data/valid) back to Dispatch_Unit and all reservation stations.

Parameters:
DATA_W, 32, operand/result width
TAG_W, 6, RST tag width
MUL_LATENCY, 3, cycles from mul accept to CDB valid (min 2)
STARVE_LIMIT, 4, blocked integer cycles before mul issue is throttled (min 1)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-low
int_ready  in  1  integer RS has an instruction ready
int_rs1_data  in  DATA_W  operand 1
int_rs2_data  in  DATA_W  operand 2
int_rd_tag  in  TAG_W  destination tag
int_opcode  in  4  ALU opcode
int_issue_done  out  1  accept strobe to integer RS
mul_ready  in  1  mul RS has an instruction ready
mul_rs1_data  in  DATA_W  operand 1
mul_rs2_data  in  DATA_W  operand 2
mul_rd_tag  in  TAG_W  destination tag
mul_issue_done  out  1  accept strobe to mul RS
cdb_valid  out  1  CDB broadcast valid
cdb_tag  out  TAG_W  broadcast tag
cdb_data  out  DATA_W  broadcast result

Behaviour:
- Clock is clk. Reset is reset, synchronous and active-low. While reset=0 at a rising edge: all pipeline valids, starvation counter and CDB registers clear. cdb_valid=0, cdb_tag=0, cdb_data=0.
- issue_done outputs are combinational. They are forced to 0 while reset=0.
- Handshake: a transfer occurs in cycle c when ready && issue_done are both high. The RS retires the entry at the edge ending cycle c. issue_done never asserts without ready.
- Mul accept: mul_issue_done = mul_ready && !throttle. Mul is fully pipelined, one accept per cycle.
- Mul result: mul accepted in cycle c drives cdb_valid in cycle c+MUL_LATENCY. Data is the low DATA_W bits of the unsigned product. Tag is carried through the pipeline.
- Int accept: int_issue_done = int_ready && !mul_hit. mul_hit means the mul pipeline stage due for the CDB at the next edge is valid, i.e. a mul was accepted in cycle c+1-MUL_LATENCY.
- Int result: int accepted in cycle c drives cdb_valid in cycle c+1.
- CDB priority: mul always wins. Int is never accepted into a collision, so no result is ever dropped. cdb_valid is high for exactly one cycle per accepted instruction.
- When neither source completes, cdb_valid=0 and tag/data hold their last values.
- ALU opcodes:
  - 0 ADD, 1 SUB: modulo 2^DATA_W, no flags.
  - 2 AND, 3 OR, 4 XOR.
  - 5 SLL, 6 SRL, 7 SRA: shift amount is rs2[4:0].
  - 8 SLT (signed), 9 SLTU: result 1/0.
  - 10–15: result 0, still broadcast with tag.
- Starvation counter:
  - Increments (saturating at STARVE_LIMIT) each cycle int_ready && !int_issue_done.
  - Clears at an edge where int is accepted, or where int_ready=0.
  - throttle = (counter == STARVE_LIMIT).
  - Worst-case int wait is STARVE_LIMIT+MUL_LATENCY-1 blocked cycles.
- Reset mid-operation: in-flight mul and int results are discarded and never broadcast.

Optional Feature:
CDB_BRANCH_EN
- Defined:
  - Adds outputs cdb_branch (1) and cdb_branch_taken (1), registered with the CDB and reset to 0.
  - Opcode 10 = BEQ, 11 = BNE. They compare rs1/rs2 and set cdb_branch=1 and cdb_branch_taken=compare result alongside cdb_valid; cdb_data=0.
  - cdb_branch=0 for all other results.
- Undefined: ports absent; opcodes 10/11 behave as 10–15 (result 0).

Decomposition:
- Package issue_pkg: DATA_W/TAG_W defaults and the opcode localparams ALU_ADD..ALU_SLTU, BR_BEQ, BR_BNE.
- Sub-module mul_pipe: MUL_LATENCY-1 register stages of {valid, tag, product}, exposing the last-stage valid for mul_hit.
- ALU and arbitration stay in the top module.

Test Plan:
1. Reset released, int_ready, rs1=5, rs2=7, op ADD, tag 3 at cycle 0 -> int_issue_done=1 in cycle 0; cycle 1: cdb_valid=1, tag 3, data 12; cycle 2: cdb_valid=0.
2. Mul rs1=6, rs2=7, tag 9 at cycle 0 (MUL_LATENCY=3) -> mul_issue_done=1 in cycle 0; cdb_valid, tag 9, data 42 in cycle 3 only.
3. Collision: mul accepted cycle 0 (tag 9), int ready from cycle 2 (tag 4) -> int_issue_done=0 in cycle 2, =1 in cycle 3; CDB carries tag 9 in cycle 3, tag 4 in cycle 4.
4. Starvation (L=3, LIMIT=4): mul_ready held high, int_ready high from cycle 0 -> mul_issue_done=0 in cycles 4–6; int accepted in cycle 6; int result on CDB in cycle 7; mul resumes in cycle 7.
5. Arithmetic: SUB 0−1 -> 0xFFFFFFFF; SRA 0x80000000 by 4 -> 0xF8000000; SLT −1<1 -> 1; SLTU -> 0.
6. Reset mid-flight: mul accepted cycle 0, reset=0 in cycle 1 -> cdb_valid stays 0 through cycle 5; with CDB_BRANCH_EN, BEQ 3,3 -> cdb_branch=1, cdb_branch_taken=1.
